// File: rtl/fir_delay_line_ctrl.sv
// FIR delay-line controller.
// Writes each incoming sample into a circular BRAM buffer, then replays the newest N_TAPS
// samples, newest first, as a framed tap stream. Taps not yet filled since reset read as zero.
module fir_delay_line_ctrl #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned N_TAPS    = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sample_valid_i,
    input  logic [DATA_SIZE-1:0] sample_i,
    output logic                 ready_o,
    output logic                 overrun_o,
    output logic                 bram_wvalid_o,
    output logic [ADDR_W-1:0]    bram_waddr_o,
    output logic [DATA_SIZE-1:0] bram_wdata_o,
    output logic [ADDR_W-1:0]    bram_raddr_o,
    input  logic [DATA_SIZE-1:0] bram_rdata_i,
    output logic                 tap_valid_o,
    output logic [DATA_SIZE-1:0] tap_data_o,
    output logic [ADDR_W-1:0]    tap_idx_o,
    output logic                 tap_first_o,
    output logic                 tap_last_o
);

    // Fill count must reach N_TAPS, which may equal the full buffer depth.
    localparam int unsigned FillW = ADDR_W + 1;
    localparam logic [FillW-1:0]  FillMax = FillW'(N_TAPS);
    localparam logic [ADDR_W-1:0] KLast   = ADDR_W'(N_TAPS - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FillW-1:0]      fill_q, fill_d;
    logic [ADDR_W-1:0]     k_q, k_d;
    logic                  drain_q, drain_d;
    logic [DATA_SIZE-1:0]  sample_q, sample_d;
    logic                  ready_q, ready_d;
    logic                  overrun_q, overrun_d;

    // Stage 1: tap metadata aligned with the BRAM read latency.
    logic                  s1_valid_q;
    logic                  s1_live_q;
    logic [ADDR_W-1:0]     s1_idx_q;
    logic                  s1_first_q;
    logic                  s1_last_q;

    // Stage 2: registered tap outputs.
    logic                  tap_valid_q;
    logic [DATA_SIZE-1:0]  tap_data_q;
    logic [ADDR_W-1:0]     tap_idx_q;
    logic                  tap_first_q;
    logic                  tap_last_q;

    logic                  accept;
    logic [ADDR_W-1:0]     rd_addr;

    // ready_q is low in IDLE only for the first cycle after reset, so a sample arriving on the
    // release edge is neither accepted nor reported as an overrun.
    assign accept = (state_q == StIdle) && ready_q && sample_valid_i;

    // wr_ptr has already advanced past the written slot by the time READ starts.
    assign rd_addr = wr_ptr_q - ADDR_W'(1) - k_q;

    // Next-state, pointer, counter and handshake logic.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        k_d       = '0;
        drain_d   = 1'b0;
        sample_d  = sample_q;
        overrun_d = sample_valid_i && !ready_q && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sample_d = sample_i;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (fill_q != FillMax) begin
                    fill_d = fill_q + FillW'(1);
                end
                state_d = StRead;
            end
            StRead: begin
                if (k_q == KLast) begin
                    state_d = StDrain;
                end else begin
                    k_d = k_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d == StIdle);
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            k_q       <= '0;
            drain_q   <= 1'b0;
            sample_q  <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            k_q       <= k_d;
            drain_q   <= drain_d;
            sample_q  <= sample_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    // Tap metadata stage, one cycle behind the read address.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_live_q  <= 1'b0;
            s1_idx_q   <= '0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= (state_q == StRead);
            s1_live_q  <= ({1'b0, k_q} < fill_q);
            s1_idx_q   <= k_q;
            s1_first_q <= (k_q == '0);
            s1_last_q  <= (k_q == KLast);
        end
    end

    // Tap output stage; unfilled taps are masked to zero, idle cycles drive all zeros.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tap_valid_q <= 1'b0;
            tap_data_q  <= '0;
            tap_idx_q   <= '0;
            tap_first_q <= 1'b0;
            tap_last_q  <= 1'b0;
        end else begin
            tap_valid_q <= s1_valid_q;
            tap_data_q  <= (s1_valid_q && s1_live_q) ? bram_rdata_i : '0;
            tap_idx_q   <= s1_valid_q ? s1_idx_q : '0;
            tap_first_q <= s1_valid_q && s1_first_q;
            tap_last_q  <= s1_valid_q && s1_last_q;
        end
    end

    // BRAM ports and status outputs.
    always_comb begin
        bram_wvalid_o = (state_q == StWrite);
        bram_waddr_o  = (state_q == StWrite) ? wr_ptr_q : '0;
        bram_wdata_o  = (state_q == StWrite) ? sample_q : '0;
        bram_raddr_o  = (state_q == StRead) ? rd_addr : '0;
        ready_o       = ready_q;
        overrun_o     = overrun_q;
        tap_valid_o   = tap_valid_q;
        tap_data_o    = tap_data_q;
        tap_idx_o     = tap_idx_q;
        tap_first_o   = tap_first_q;
        tap_last_o    = tap_last_q;
    end

endmodule
